byte_serializer: RTL and testbench

Parallel-to-serial front end that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `j`, the serial input of the downstream 10010 sequence detector. A one-entry hold register plus a shift register allow gap-free streaming of back-to-back words. When no data is available, the block drives a fixed idle level and reports underrun.

---
 rtl/serializer_pkg.sv | 13 +
 rtl/word_hold_buffer.sv | 43 ++++
 rtl/byte_serializer.sv | 138 +++++++++++++
 tb/tb_byte_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and defaults for the byte serializer
// Contents:
//   ser_state_t       serializer FSM state (IDLE, SHIFT)
//   DEFAULT_WIDTH     default word width in bits
//   DEFAULT_IDLE_BIT  default level driven on j between words
package serializer_pkg;

   typedef enum logic {IDLE, SHIFT} ser_state_t;

   localparam int   DEFAULT_WIDTH    = 8;
   localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_hold_buffer.sv
// rtl/word_hold_buffer.sv - one-entry word register with full flag and ready generation
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   din        in   parallel word offered by the upstream source
//   din_valid  in   din is valid
//   din_ready  out  register empty; word taken on an edge with din_valid && din_ready
//   consume    in   serializer takes the held word this edge
//   hold       out  held word
//   hold_full  out  hold contains a word not yet taken by the serializer
module word_hold_buffer
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             consume,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full
);

   // Ready comes straight from the flag, so there is no path from din_valid.
   assign din_ready = !hold_full;

   // consume needs hold_full and an accept needs !hold_full, so the two
   // never meet on the same edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (consume) begin
         hold_full <= 1'b0;
      end else if (din_valid && !hold_full) begin
         hold      <= din;
         hold_full <= 1'b1;
      end
   end

endmodule

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel-to-serial front end feeding the 10010 detector input j
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous, active-high reset
//   din         in   parallel word
//   din_valid   in   din is valid
//   din_ready   out  hold register empty
//   j           out  serial bit, registered
//   j_active    out  j carries a data bit this cycle
//   word_start  out  j carries the first bit of a word
//   underrun    out  one-cycle pulse: a word finished with no next word held
module byte_serializer
   import serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             j,
   output logic             j_active,
   output logic             word_start,
   output logic             underrun
);

   localparam int CW = $clog2(WIDTH + 1);

   ser_state_t       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             j_nxt, j_active_nxt, word_start_nxt, underrun_nxt;
   logic             load;
   logic [WIDTH-1:0] hold;
   logic             hold_full;

   // The bit leaving on j is removed from the word, so the next bit to send
   // always sits at the output end of the shift register.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      if (MSB_FIRST)
         return {v[WIDTH-2:0], 1'b0};
      else
         return {1'b0, v[WIDTH-1:1]};
   endfunction

   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      if (MSB_FIRST)
         return v[WIDTH-1];
      else
         return v[0];
   endfunction

   word_hold_buffer #(
      .WIDTH(WIDTH)
   ) u_hold (
      .Clock     (Clock),
      .Reset     (Reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .consume   (load),
      .hold      (hold),
      .hold_full (hold_full)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         j          <= IDLE_BIT;
         j_active   <= 1'b0;
         word_start <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shreg      <= shreg_nxt;
         j          <= j_nxt;
         j_active   <= j_active_nxt;
         word_start <= word_start_nxt;
         underrun   <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      shreg_nxt      = shreg;
      j_nxt          = IDLE_BIT;
      j_active_nxt   = 1'b0;
      word_start_nxt = 1'b0;
      underrun_nxt   = 1'b0;
      load           = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (hold_full)
               load = 1'b1;
         end
         SHIFT: begin
            if (cnt != CW'(WIDTH)) begin
               j_nxt        = out_bit(shreg);
               j_active_nxt = 1'b1;
               shreg_nxt    = advance(shreg);
               cnt_nxt      = cnt + CW'(1);
            end else if (hold_full) begin
               // Next word goes out on the edge right after the last bit.
               load = 1'b1;
            end else begin
               underrun_nxt = 1'b1;
               cnt_nxt      = '0;
               state_nxt    = IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase

      // First bit leaves directly from the hold register; the remainder
      // is parked in the shifter already advanced by one position.
      if (load) begin
         j_nxt          = out_bit(hold);
         j_active_nxt   = 1'b1;
         word_start_nxt = 1'b1;
         shreg_nxt      = advance(hold);
         cnt_nxt        = CW'(1);
         state_nxt      = SHIFT;
      end
   end

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - scoreboard bench for byte_serializer (MSB-first and LSB-first instances)
module tb_byte_serializer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;

   logic [7:0] din_m = '0, din_l = '0;
   logic       valid_m = 1'b0, valid_l = 1'b0;
   logic       ready_m, j_m, act_m, ws_m, ur_m;
   logic       ready_l, j_l, act_l, ws_l, ur_l;

   int checks = 0;
   int errors = 0;

   logic [1:0] q_m[$];
   logic [1:0] q_l[$];
   int         ur_cnt_m = 0, ur_cnt_l = 0;
   int         gaps_m = 0;
   int         det_m = 0;
   int         ones_m = 0;
   logic [3:0] hist_m = '0;
   logic       prev_act_m = 1'b0, prev_act_l = 1'b0;

   always #5 Clock = ~Clock;

   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .Clock(Clock), .Reset(Reset), .din(din_m), .din_valid(valid_m), .din_ready(ready_m),
      .j(j_m), .j_active(act_m), .word_start(ws_m), .underrun(ur_m));

   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .Clock(Clock), .Reset(Reset), .din(din_l), .din_valid(valid_l), .din_ready(ready_l),
      .j(j_l), .j_active(act_l), .word_start(ws_l), .underrun(ur_l));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: pop one expected {bit, word_start} per active cycle.
   always @(negedge Clock) begin
      logic [1:0] e;
      if (Reset) begin
         prev_act_m = 1'b0;
         hist_m     = '0;
      end else begin
         if (act_m) begin
            ones_m += int'(j_m);
            if (q_m.size() == 0) begin
               check("m_unexpected_bit", 32'(act_m), 32'(0));
            end else begin
               e = q_m.pop_front();
               check("m_j", 32'(j_m), 32'(e[1]));
               check("m_word_start", 32'(ws_m), 32'(e[0]));
            end
            if ({hist_m, j_m} == 5'b10010) det_m++;
            hist_m = {hist_m[2:0], j_m};
         end else begin
            check("m_idle_level", 32'(j_m), 32'(0));
            hist_m = '0;
            if (prev_act_m && q_m.size() != 0) gaps_m++;
         end
         if (ur_m) begin
            ur_cnt_m++;
            check("m_underrun_timing", 32'({prev_act_m, act_m}), 32'(2'b10));
         end
         prev_act_m = act_m;
      end
   end

   always @(negedge Clock) begin
      logic [1:0] e;
      if (Reset) begin
         prev_act_l = 1'b0;
      end else begin
         if (act_l) begin
            if (q_l.size() == 0) begin
               check("l_unexpected_bit", 32'(act_l), 32'(0));
            end else begin
               e = q_l.pop_front();
               check("l_j", 32'(j_l), 32'(e[1]));
               check("l_word_start", 32'(ws_l), 32'(e[0]));
            end
         end
         if (ur_l) begin
            ur_cnt_l++;
            check("l_underrun_timing", 32'({prev_act_l, act_l}), 32'(2'b10));
         end
         prev_act_l = act_l;
      end
   end

   // Offer a word on the MSB-first instance; din_valid is left high.
   task automatic send_m(input logic [7:0] w);
      int n = 0;
      @(negedge Clock);
      din_m   = w;
      valid_m = 1'b1;
      while (!ready_m && n < 100) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 100) check("m_ready_timeout", 32'(ready_m), 32'(1));
      @(posedge Clock);
      for (int i = 7; i >= 0; i--) q_m.push_back({w[i], (i == 7) ? 1'b1 : 1'b0});
      #1;
      check("m_ready_drop", 32'(ready_m), 32'(0));
   endtask

   task automatic send_l(input logic [7:0] w);
      int n = 0;
      @(negedge Clock);
      din_l   = w;
      valid_l = 1'b1;
      while (!ready_l && n < 100) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 100) check("l_ready_timeout", 32'(ready_l), 32'(1));
      @(posedge Clock);
      for (int i = 0; i < 8; i++) q_l.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
      #1;
      check("l_ready_drop", 32'(ready_l), 32'(0));
   endtask

   task automatic drain(input bit lsb);
      int n = 0;
      while (((lsb ? q_l.size() : q_m.size()) != 0) && n < 200) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 200) check("drain_timeout", 32'(lsb ? q_l.size() : q_m.size()), 32'(0));
      repeat (3) @(negedge Clock);
   endtask

   initial begin
      int ur0;

      // Reset state
      repeat (3) @(negedge Clock);
      check("rst_j", 32'(j_m), 32'(0));
      check("rst_active", 32'(act_m), 32'(0));
      check("rst_word_start", 32'(ws_m), 32'(0));
      check("rst_underrun", 32'(ur_m), 32'(0));
      check("rst_ready", 32'(ready_m), 32'(1));
      check("rst_ready_l", 32'(ready_l), 32'(1));
      Reset = 1'b0;
      repeat (2) @(negedge Clock);

      // Single word 8'h92: two 10010 hits, one underrun
      det_m = 0;
      ur0   = ur_cnt_m;
      send_m(8'h92);
      @(negedge Clock);
      valid_m = 1'b0;
      drain(1'b0);
      check("single_detect", 32'(det_m), 32'(2));
      check("single_underrun", 32'(ur_cnt_m - ur0), 32'(1));
      check("single_gaps", 32'(gaps_m), 32'(0));

      // Back-to-back A5, 3C with valid held
      ur0 = ur_cnt_m;
      send_m(8'hA5);
      send_m(8'h3C);
      @(negedge Clock);
      valid_m = 1'b0;
      drain(1'b0);
      check("b2b_underrun", 32'(ur_cnt_m - ur0), 32'(1));
      check("b2b_gaps", 32'(gaps_m), 32'(0));

      // Backpressure: three queued words
      ur0 = ur_cnt_m;
      send_m(8'h5A);
      send_m(8'hC3);
      send_m(8'h0F);
      @(negedge Clock);
      valid_m = 1'b0;
      drain(1'b0);
      check("bp_underrun", 32'(ur_cnt_m - ur0), 32'(1));
      check("bp_gaps", 32'(gaps_m), 32'(0));

      // LSB-first 8'h01
      ur0 = ur_cnt_l;
      send_l(8'h01);
      @(negedge Clock);
      valid_l = 1'b0;
      drain(1'b1);
      check("lsb_underrun", 32'(ur_cnt_l - ur0), 32'(1));

      // Reset after the 3rd bit of 8'hFF
      begin
         int n = 0;
         ur0 = ur_cnt_m;
         send_m(8'hFF);
         @(negedge Clock);
         valid_m = 1'b0;
         while (q_m.size() > 5 && n < 50) begin
            @(negedge Clock);
            n++;
         end
         if (n >= 50) check("mid_reset_timeout", 32'(q_m.size()), 32'(5));
         #2;
         Reset = 1'b1;
         #1;
         check("mid_rst_j", 32'(j_m), 32'(0));
         check("mid_rst_active", 32'(act_m), 32'(0));
         check("mid_rst_ready", 32'(ready_m), 32'(1));
         q_m.delete();
         repeat (2) @(negedge Clock);
         Reset  = 1'b0;
         ones_m = 0;
         repeat (12) @(negedge Clock);
         check("post_rst_ones", 32'(ones_m), 32'(0));
         check("post_rst_underrun", 32'(ur_cnt_m - ur0), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
